// File: rtl/if_stage_if.sv
// Port bundle for the instruction-fetch stage: pipeline control in, ROM
// fetch bus, and the IF/ID latch outputs toward decode.
// Optional macro FETCH_ALIGN_CHECK_EN adds the fetch_misalign_o signal.
interface if_stage_if;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign_o;
`endif

    // Fetch-stage side: owns the PC, ROM enable and IF/ID latch
    modport master (
        input  stall_if, stall_id, flush, new_pc,
        input  branch_flag_i, branch_target_address_i, inst_i,
        output pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o
`ifdef FETCH_ALIGN_CHECK_EN
        , output fetch_misalign_o
`endif
    );

    // Environment side: control block, decode stage and instruction ROM
    modport slave (
        output stall_if, stall_id, flush, new_pc,
        output branch_flag_i, branch_target_address_i, inst_i,
        input  pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o
`ifdef FETCH_ALIGN_CHECK_EN
        , input fetch_misalign_o
`endif
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, ROM chip enable and IF/ID latch.
// Handles stalls, branch redirects from ID and exception flushes.
// Optional macro FETCH_ALIGN_CHECK_EN flags misaligned fetches and turns them
// into NOPs while keeping their PC for EPC capture.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic   clk,
    input  logic   rst,          // asynchronous, active low
    if_stage_if.master bus
);

    logic [31:0] pc_reg, pc_next;
    logic        ce_reg, ce_next;
    logic [31:0] id_pc_reg, id_pc_next;
    logic [31:0] id_inst_reg, id_inst_next;
    logic        id_valid_reg, id_valid_next;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_reg, misalign_next;
    logic        fetch_misaligned;
`endif

    // PC and chip-enable next state: flush > stall > branch > sequential
    always_comb begin
        pc_next = pc_reg;
        ce_next = bus.stall_if ? ce_reg : 1'b1;
        if (ce_reg) begin
            if (bus.flush)
                pc_next = bus.new_pc;
            else if (bus.stall_if)
                pc_next = pc_reg;
            else if (bus.branch_flag_i)
                pc_next = bus.branch_target_address_i;
            else
                pc_next = pc_reg + PC_INC;   // wraps modulo 2^32
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // A live fetch from a non-word address cannot be decoded
    assign fetch_misaligned = ce_reg && (pc_reg[1:0] != 2'b00);
`endif

    // IF/ID latch next state: flush bubble > ID hold > IF-stall bubble > load
    always_comb begin
        id_pc_next    = id_pc_reg;
        id_inst_next  = id_inst_reg;
        id_valid_next = id_valid_reg;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_next = misalign_reg;
`endif
        if (bus.flush || (bus.stall_if && !bus.stall_id)) begin
            id_pc_next    = 32'h0;
            id_inst_next  = 32'h0;
            id_valid_next = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_next = 1'b0;
`endif
        end else if (!bus.stall_id) begin
            id_pc_next    = pc_reg;
            id_valid_next = ce_reg;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_next = fetch_misaligned;
            id_inst_next  = fetch_misaligned ? 32'h0 : bus.inst_i;
`else
            id_inst_next  = bus.inst_i;
`endif
        end
    end

    // State registers with immediate clear on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg       <= RESET_PC;
            ce_reg       <= 1'b0;
            id_pc_reg    <= 32'h0;
            id_inst_reg  <= 32'h0;
            id_valid_reg <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            pc_reg       <= pc_next;
            ce_reg       <= ce_next;
            id_pc_reg    <= id_pc_next;
            id_inst_reg  <= id_inst_next;
            id_valid_reg <= id_valid_next;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_reg <= misalign_next;
`endif
        end
    end

    assign bus.pc_o       = pc_reg;
    assign bus.ce_o       = ce_reg;
    assign bus.id_pc_o    = id_pc_reg;
    assign bus.id_inst_o  = id_inst_reg;
    assign bus.id_valid_o = id_valid_reg;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fetch_misalign_o = misalign_reg;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, branch with delay
// slot, IF stall, combined stall with branch, flush, async reset mid-run.
// Optional macro FETCH_ALIGN_CHECK_EN enables the misaligned-fetch checks.
module tb_if_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction ROM: word at byte address a is {8'hA5, a[25:2]}
    always_comb bus.inst_i = {8'hA5, bus.pc_o[25:2]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic ce,
                             input logic [31:0] idpc, input logic [31:0] idinst, input logic idv);
        check({tag, ".pc_o"},       bus.pc_o,       pc);
        check({tag, ".ce_o"},       {31'h0, bus.ce_o}, {31'h0, ce});
        check({tag, ".id_pc_o"},    bus.id_pc_o,    idpc);
        check({tag, ".id_inst_o"},  bus.id_inst_o,  idinst);
        check({tag, ".id_valid_o"}, {31'h0, bus.id_valid_o}, {31'h0, idv});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // stall_id without stall_if is an illegal control combination
    always @(negedge clk) begin
        if (rst && bus.stall_id && !bus.stall_if) begin
            n_cmp++;
            assert (0) else begin
                n_err++;
                $error("FAIL illegal_stall: observed stall_id=1 stall_if=0 expected stall_if=1");
            end
        end
    end

    initial begin
        bus.stall_if = 0; bus.stall_id = 0; bus.flush = 0; bus.new_pc = 0;
        bus.branch_flag_i = 0; bus.branch_target_address_i = 0;

        #2 rst = 0;
        #1 check_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("reset.misalign", {31'h0, bus.fetch_misalign_o}, 32'h0);
`endif
        @(posedge clk); @(posedge clk);
        #3 rst = 1;

        // Sequential fetch from RESET_PC
        step(); check_all("e1", 32'h0, 1'b1, 32'h0, 32'hA500_0000, 1'b0);
        step(); check_all("e2", 32'h4, 1'b1, 32'h0, 32'hA500_0000, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
        check("e2.misalign", {31'h0, bus.fetch_misalign_o}, 32'h0);
`endif
        step(); check_all("e3", 32'h8, 1'b1, 32'h4, 32'hA500_0001, 1'b1);

        // Branch to 0x100 while pc=8: delay slot at 8 still latched
        bus.branch_flag_i = 1; bus.branch_target_address_i = 32'h100;
        step(); check_all("br", 32'h100, 1'b1, 32'h8, 32'hA500_0002, 1'b1);
        bus.branch_flag_i = 0;
        step(); check_all("br+1", 32'h104, 1'b1, 32'h100, 32'hA500_0040, 1'b1);

        // Redirect to 0x10 for the stall test
        bus.branch_flag_i = 1; bus.branch_target_address_i = 32'h10;
        step(); check_all("br10", 32'h10, 1'b1, 32'h104, 32'hA500_0041, 1'b1);
        bus.branch_flag_i = 0;

        // stall_if alone for two cycles: PC holds, bubbles into ID
        bus.stall_if = 1;
        step(); check_all("sif1", 32'h10, 1'b1, 32'h0, 32'h0, 1'b0);
        step(); check_all("sif2", 32'h10, 1'b1, 32'h0, 32'h0, 1'b0);
        bus.stall_if = 0;
        step(); check_all("sif_rel", 32'h14, 1'b1, 32'h10, 32'hA500_0004, 1'b1);

        // Both stalls with a pending branch: everything holds
        bus.stall_if = 1; bus.stall_id = 1;
        bus.branch_flag_i = 1; bus.branch_target_address_i = 32'h200;
        step(); check_all("sboth1", 32'h14, 1'b1, 32'h10, 32'hA500_0004, 1'b1);
        step(); check_all("sboth2", 32'h14, 1'b1, 32'h10, 32'hA500_0004, 1'b1);
        bus.stall_id = 0; bus.stall_if = 0;
        step(); check_all("sboth_rel", 32'h200, 1'b1, 32'h14, 32'hA500_0005, 1'b1);

        // Flush overrides concurrent stall and branch
        bus.flush = 1; bus.new_pc = 32'h20; bus.stall_if = 1;
        bus.branch_flag_i = 1; bus.branch_target_address_i = 32'h300;
        step(); check_all("flush", 32'h20, 1'b1, 32'h0, 32'h0, 1'b0);
        bus.flush = 0; bus.stall_if = 0; bus.branch_flag_i = 0;
        step(); check_all("flush+1", 32'h24, 1'b1, 32'h20, 32'hA500_0008, 1'b1);

        // PC wrap at the top of the address space
        bus.branch_flag_i = 1; bus.branch_target_address_i = 32'hFFFF_FFFC;
        step(); check("wrap.pre", bus.pc_o, 32'hFFFF_FFFC);
        bus.branch_flag_i = 0;
        step(); check("wrap.pc", bus.pc_o, 32'h0);

        // Go to 0x40, then pulse reset low between edges
        bus.branch_flag_i = 1; bus.branch_target_address_i = 32'h40;
        step(); check("pre_rst.pc", bus.pc_o, 32'h40);
        bus.branch_flag_i = 0;
        #2 rst = 0;
        #1 check_all("async_rst", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2 rst = 1;
        step(); check_all("rst_e1", 32'h0, 1'b1, 32'h0, 32'hA500_0000, 1'b0);
        step(); check_all("rst_e2", 32'h4, 1'b1, 32'h0, 32'hA500_0000, 1'b1);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned branch target: latched as NOP with PC kept
        bus.branch_flag_i = 1; bus.branch_target_address_i = 32'h102;
        step(); check("mis.pc", bus.pc_o, 32'h102);
        bus.branch_flag_i = 0;
        step();
        check("mis.flag", {31'h0, bus.fetch_misalign_o}, 32'h1);
        check("mis.inst", bus.id_inst_o, 32'h0);
        check("mis.id_pc", bus.id_pc_o, 32'h102);
        check("mis.valid", {31'h0, bus.id_valid_o}, 32'h1);
        bus.flush = 1; bus.new_pc = 32'h0;
        step(); check("mis.flush", {31'h0, bus.fetch_misalign_o}, 32'h0);
        bus.flush = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Holds the program counter (PC) and drives the address and chip-enable of the instruction ROM.
- Takes the instruction word the ROM returns in the same cycle and registers the PC/instruction pair into the IF/ID pipeline latch for the decode stage.
- Handles pipeline stalls, branch redirects from ID and exception flushes from the control block.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded at reset and fetched first.
- PC_INC, 4: byte increment for sequential fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_if  in  1  hold the PC and ce_o.
- stall_id  in  1  hold the IF/ID latch; legal only together with stall_if=1.
- flush  in  1  exception flush from control.
- new_pc  in  32  exception handler address, used when flush=1.
- branch_flag_i  in  1  taken branch/jump from ID.
- branch_target_address_i  in  32  redirect target from ID.
- inst_i  in  32  instruction word from the ROM (combinational in pc_o).
- pc_o  out  32  fetch address to the ROM.
- ce_o  out  1  ROM chip enable.
- id_pc_o  out  32  PC of the instruction held in the IF/ID latch.
- id_inst_o  out  32  instruction held in the IF/ID latch.
- id_valid_o  out  1  IF/ID latch holds a real instruction (not a bubble).

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-operation):
  - pc_o=RESET_PC, ce_o=0.
  - id_pc_o=0, id_inst_o=0, id_valid_o=0.
- First rising edge after rst is released: ce_o<=1, pc_o stays RESET_PC. The first fetched address is therefore RESET_PC.
- PC update while ce_o=1, evaluated at each edge in this priority:
  1. flush=1: pc_o<=new_pc.
  2. stall_if=1: pc_o holds.
  3. branch_flag_i=1: pc_o<=branch_target_address_i.
  4. Otherwise: pc_o<=pc_o+PC_INC.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- While ce_o=0 the PC does not advance.
- IF/ID latch update at each edge, in this priority:
  1. flush=1: bubble (id_pc_o=0, id_inst_o=0, id_valid_o=0).
  2. stall_id=1: hold all three outputs.
  3. stall_if=1 and stall_id=0: bubble.
  4. Otherwise: id_pc_o<=pc_o, id_inst_o<=inst_i, id_valid_o<=ce_o.
- Branch delay slot: the instruction at the branch PC+4 is already in IF when branch_flag_i is asserted. It is latched normally; no squash.
- Simultaneous events:
  - flush overrides stall and branch.
  - stall_if with branch_flag_i holds the PC; ID re-presents the branch while it is stalled.
- stall_id=1 with stall_if=0 is illegal; the bench flags it with an assertion.
- Latency: the instruction at pc_o appears on id_inst_o one edge later.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Extra output port fetch_misalign_o (1 bit), registered alongside the IF/ID latch. It is set when the latched pc_o[1:0]!=2'b00 and ce_o=1.
  - A misaligned fetch forces id_inst_o=0 (NOP) but keeps id_pc_o for EPC capture.
  - Reset value 0; cleared on bubble and on flush.
- Not defined: the port is absent, no alignment check, and branch targets are used as-is.

Test Plan:
- Reset release with no stalls:
  - Edge 1 after release: ce_o=1, pc_o=0.
  - Subsequent edges: pc_o=4, 8, 12.
  - id_pc_o lags pc_o by one edge.
  - id_inst_o equals ROM words 0, 1, 2 with id_valid_o=1.
- Branch: branch_flag_i=1 with target 32'h0000_0100 while pc_o=8.
  - Next edge: pc_o=0x100.
  - Delay-slot instruction at 8 is latched with id_valid_o=1.
- stall_if=1, stall_id=0 for 2 cycles at pc_o=0x10:
  - pc_o holds 0x10.
  - id_valid_o=0 for 2 cycles.
  - On release, fetch resumes at 0x10 with no instruction lost or duplicated.
- stall_if=1, stall_id=1 together with branch_flag_i=1: pc_o and the IF/ID latch hold unchanged for each stalled cycle.
- flush=1, new_pc=32'h0000_0020, asserted concurrently with stall_if=1 and branch_flag_i=1:
  - Next edge: pc_o=0x20.
  - IF/ID latch is a bubble (all zero).
- Async reset mid-run at pc_o=0x40, rst pulsed low between edges:
  - All outputs clear immediately without a clock edge.
  - Restart from pc_o=0.
  - With FETCH_ALIGN_CHECK_EN defined, a branch to 0x102 sets fetch_misalign_o=1, id_inst_o=0 and id_pc_o=0x102.
